pc_unit: RTL

//  Parametrised next-generation program counter for the MIPS core fetch stage.

---
 rtl/pc_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Fetch-stage program counter with priority next-PC selection,
//            stall hold, redirect pulse and optional return-address stack
//            (enabled by defining PC_RAS_EN).
// Revision : 1.0
// ============================================================================
module pc_unit #(
   parameter int                N_BITS     = 32,
   parameter logic [N_BITS-1:0] RESET_PC   = 32'h00400000,
   parameter logic [N_BITS-1:0] EXC_VECTOR = 32'h80000180,
   parameter int                RAS_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_i,
   input  logic              branch_taken_i,
   input  logic [N_BITS-1:0] branch_target_i,
   input  logic              jump_i,
   input  logic [N_BITS-1:0] jump_target_i,
   input  logic              call_i,
   input  logic              ret_i,
   input  logic [N_BITS-1:0] ret_target_i,
   input  logic              exc_i,
   output logic [N_BITS-1:0] pc_value_o,
   output logic [N_BITS-1:0] pc_plus4_o,
   output logic              redirect_o,
   output logic              misaligned_o,
   output logic              ras_underflow_o
);

   logic [N_BITS-1:0] r_pc;
   logic              r_redirect;
   logic              r_misaligned;

   logic [N_BITS-1:0] w_pc_plus4;
   logic [N_BITS-1:0] w_ret_addr;
   logic [N_BITS-1:0] w_target;
   logic              w_load;
   logic              w_take;
   logic              w_push;
   logic              w_pop;

   assign w_pc_plus4 = r_pc + N_BITS'(4);
   assign w_take     = ~exc_i & ~stall_i;
   assign w_pop      = w_take & ret_i;
   assign w_push     = w_take & ~ret_i & jump_i & call_i;

   always_comb begin
      w_target = '0;
      w_load   = 1'b0;
      if (exc_i) begin
         w_target = EXC_VECTOR;
         w_load   = 1'b1;
      end else if (!stall_i) begin
         if (ret_i) begin
            w_target = w_ret_addr;
            w_load   = 1'b1;
         end else if (jump_i) begin
            w_target = jump_target_i;
            w_load   = 1'b1;
         end else if (branch_taken_i) begin
            w_target = branch_target_i;
            w_load   = 1'b1;
         end
      end
   end

   // Stall without exception holds PC and misaligned; only redirect drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc         <= RESET_PC;
         r_redirect   <= 1'b0;
         r_misaligned <= 1'b0;
      end else if (exc_i || !stall_i) begin
         r_pc         <= w_load ? {w_target[N_BITS-1:2], 2'b00} : w_pc_plus4;
         r_redirect   <= w_load;
         r_misaligned <= w_load & (|w_target[1:0]);
      end else begin
         r_redirect   <= 1'b0;
      end
   end

`ifdef PC_RAS_EN
   localparam int c_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int c_CNT_W = $clog2(RAS_DEPTH + 1);

   logic [N_BITS-1:0]  r_ras [RAS_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               r_ras_underflow;
   logic [c_PTR_W-1:0] w_top_ptr;
   logic [c_PTR_W-1:0] w_wr_next;
   logic               w_ras_hit;

   // Circular buffer: r_wr_ptr is the next free slot, the top sits just below.
   assign w_top_ptr  = (r_wr_ptr == '0) ? c_PTR_W'(RAS_DEPTH - 1)
                                        : r_wr_ptr - c_PTR_W'(1);
   assign w_wr_next  = (r_wr_ptr == c_PTR_W'(RAS_DEPTH - 1)) ? '0
                                        : r_wr_ptr + c_PTR_W'(1);
   assign w_ras_hit  = (r_count != '0);
   assign w_ret_addr = w_ras_hit ? r_ras[w_top_ptr] : ret_target_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr        <= '0;
         r_count         <= '0;
         r_ras_underflow <= 1'b0;
      end else begin
         r_ras_underflow <= w_pop & ~w_ras_hit;
         if (w_push) begin
            r_wr_ptr <= w_wr_next;
            if (r_count != c_CNT_W'(RAS_DEPTH))
               r_count <= r_count + c_CNT_W'(1);
         end else if (w_pop && w_ras_hit) begin
            r_wr_ptr <= w_top_ptr;
            r_count  <= r_count - c_CNT_W'(1);
         end
      end
   end

   // Entry storage carries no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (!reset && w_push)
         r_ras[r_wr_ptr] <= w_pc_plus4;
   end

   assign ras_underflow_o = r_ras_underflow;
`else
   logic w_unused_ras;

   assign w_ret_addr      = ret_target_i;
   assign ras_underflow_o = 1'b0;
   assign w_unused_ras    = w_push | w_pop;
`endif

   assign pc_value_o   = r_pc;
   assign pc_plus4_o   = w_pc_plus4;
   assign redirect_o   = r_redirect;
   assign misaligned_o = r_misaligned;

endmodule
`default_nettype wire
